alu_md_controller: RTL

- Parametrised successor of the EX-stage ALU controller.
- Keeps the existing ALUOp/Funct3/Funct7 → 4-bit Operation decode (combinational) and adds an XLEN-generic RV32M/RV64M multiply/divide sequencer.
- The sequencer is iterative: one bit per cycle, with a stall handshake to the hazard unit.
- Sits in EX beside the ALU; the pipeline muxes md_result over the ALU result when md_valid is high.

---
 rtl/alu_md_controller.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/alu_md_controller.sv
// EX-stage ALU operation decode plus an iterative RV32M/RV64M multiply/divide sequencer.
// Optional: define MD_ZERO_BYPASS_EN to finish multiplies with a zero operand in one cycle.
module alu_md_controller #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            valid_i,
  input  logic            RType,
  input  logic [1:0]      ALUOp,
  input  logic [6:0]      Funct7,
  input  logic [2:0]      Funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            flush_i,
  output logic [3:0]      Operation,
  output logic            stall_o,
  output logic            md_valid,
  output logic [XLEN-1:0] md_result
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t              state, next;
  logic [CNT_W-1:0]    cnt;
  logic [2*XLEN-1:0]   acc;
  logic [XLEN-1:0]     opb;
  logic [XLEN-1:0]     hold;
  logic [2:0]          f3_q;
  logic                neg;

  logic                md_op, start, last, bypass;
  logic                sa, sb, b_zero, ovf, special;
  logic [XLEN-1:0]     a_mag, b_mag;
  logic [XLEN:0]       msum, rsh, dif;
  logic                qb;
  logic [2*XLEN-1:0]   mul_next, div_next, full;
  logic [XLEN-1:0]     part, result;

  assign md_op = valid_i & RType & (ALUOp == 2'b10) & (Funct7 == 7'b0000001);
  assign start = md_op & ~flush_i;
  assign last  = (cnt == CNT_W'(XLEN - 1));

  always_comb begin
    Operation = 4'b0000;
    case (ALUOp)
      2'b00: Operation = 4'b0011;
      2'b01: begin
        case (Funct3)
          3'b000:  Operation = 4'b0101;
          3'b001:  Operation = 4'b0110;
          3'b100:  Operation = 4'b0111;
          3'b101:  Operation = 4'b1000;
          default: Operation = 4'b0000;
        endcase
      end
      2'b10: begin
        if (md_op) Operation = 4'b0011;
        else begin
          // Funct7[5] separates SUB/SRA, which this ALU does not decode
          case (Funct3)
            3'b000:  if (!RType || !Funct7[5]) Operation = 4'b0011;
            3'b001:  if (!Funct7[5]) Operation = 4'b1010;
            3'b010:  Operation = 4'b0111;
            3'b100:  Operation = 4'b0010;
            3'b101:  if (!Funct7[5]) Operation = 4'b1001;
            3'b110:  Operation = 4'b0001;
            default: Operation = 4'b0000;
          endcase
        end
      end
      default: Operation = 4'b1100;
    endcase
  end

  // Operand signedness: mul 000/001 s*s, 010 s*u, 011 u*u; div 100/110 signed
  always_comb begin
    sa      = Funct3[2] ? (~Funct3[0] & rs1[XLEN-1]) : ((Funct3[1:0] != 2'b11) & rs1[XLEN-1]);
    sb      = Funct3[2] ? (~Funct3[0] & rs2[XLEN-1]) : (~Funct3[1] & rs2[XLEN-1]);
    a_mag   = sa ? -rs1 : rs1;
    b_mag   = sb ? -rs2 : rs2;
    b_zero  = (rs2 == '0);
    ovf     = ~Funct3[0] & (rs1 == {1'b1, {(XLEN-1){1'b0}}}) & (rs2 == '1);
    special = b_zero | ovf;
  end

`ifdef MD_ZERO_BYPASS_EN
  assign bypass = (rs1 == '0) | (rs2 == '0);
`else
  assign bypass = 1'b0;
`endif

  // acc = {high, low}: shift-add product, or {remainder, quotient} for divide
  always_comb begin
    msum     = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opb} : '0);
    mul_next = {msum, acc[XLEN-1:1]};
    rsh      = acc[2*XLEN-1:XLEN-1];
    dif      = rsh - {1'b0, opb};
    qb       = ~dif[XLEN];
    div_next = {(qb ? dif[XLEN-1:0] : rsh[XLEN-1:0]), acc[XLEN-2:0], qb};
  end

  always_comb begin
    full = neg ? -acc : acc;
    part = f3_q[1] ? acc[2*XLEN-1:XLEN] : acc[XLEN-1:0];
    if (f3_q[2])               result = neg ? -part : part;
    else if (f3_q[1:0] == 2'b00) result = full[XLEN-1:0];
    else                       result = full[2*XLEN-1:XLEN];
  end

  always_comb begin
    next     = state;
    stall_o  = 1'b0;
    md_valid = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          stall_o = 1'b1;
          if (!Funct3[2]) next = bypass ? DONE : MUL;
          else            next = special ? DONE : DIV;
        end
      end
      MUL, DIV: begin
        if (flush_i) next = IDLE;
        else begin
          stall_o = 1'b1;
          if (last) next = DONE;
        end
      end
      default: begin
        md_valid = ~flush_i;
        next     = IDLE;
      end
    endcase
  end

  assign md_result = md_valid ? result : hold;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      acc   <= '0;
      opb   <= '0;
      hold  <= '0;
      f3_q  <= '0;
      neg   <= 1'b0;
    end else begin
      state <= next;
      case (state)
        IDLE: begin
          if (start) begin
            f3_q <= Funct3;
            cnt  <= '0;
            if (!Funct3[2]) begin
              opb <= a_mag;
              neg <= bypass ? 1'b0 : (sa ^ sb);
              acc <= bypass ? '0 : {{XLEN{1'b0}}, b_mag};
            end else begin
              opb <= b_mag;
              // special results are loaded already in {rem, quo} form, unsigned
              if (b_zero) begin
                neg <= 1'b0;
                acc <= {rs1, {XLEN{1'b1}}};
              end else if (ovf) begin
                neg <= 1'b0;
                acc <= {{XLEN{1'b0}}, rs1};
              end else begin
                neg <= Funct3[1] ? sa : (sa ^ sb);
                acc <= {{XLEN{1'b0}}, a_mag};
              end
            end
          end
        end
        MUL: begin
          acc <= mul_next;
          cnt <= cnt + 1'b1;
        end
        DIV: begin
          acc <= div_next;
          cnt <= cnt + 1'b1;
        end
        default: begin
          if (md_valid) hold <= result;
        end
      endcase
    end
  end

endmodule
